// File: rtl/vga_pixel_gen_pkg.sv
// Shared constants for the VGA pixel generator: playfield geometry defaults,
// the arcade colour palette and the colour-band lookup.
package vga_pixel_gen_pkg;

  // Playfield geometry defaults.
  localparam int DEF_FB_W        = 224;
  localparam int DEF_FB_H        = 240;
  localparam int DEF_SCALE_SHIFT = 1;
  localparam int DEF_ORIGIN_X    = 96;
  localparam int DEF_ORIGIN_Y    = 0;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_RED_ROWS    = 32;
  localparam int DEF_GREEN_ROWS  = 56;

  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [11:0]        rgb_t;

  // 12-bit {R,G,B} palette.
  localparam rgb_t RGB_BLACK = 12'h000;
  localparam rgb_t RGB_WHITE = 12'hFFF;
  localparam rgb_t RGB_RED   = 12'hF00;
  localparam rgb_t RGB_GREEN = 12'h0F0;

  typedef enum logic [1:0] {
    BAND_RED,
    BAND_WHITE,
    BAND_GREEN
  } band_e;

  // Which overlay band a framebuffer row falls in.
  function automatic band_e band_of(coord_t fy, coord_t red_rows, coord_t green_first);
    if (fy < red_rows)         return BAND_RED;
    else if (fy >= green_first) return BAND_GREEN;
    else                        return BAND_WHITE;
  endfunction

  // Final colour of one pixel: lit pixels take their band colour, all else black.
  function automatic rgb_t pixel_colour(logic lit, coord_t fy, coord_t red_rows,
                                        coord_t green_first);
    if (!lit) return RGB_BLACK;
    case (band_of(fy, red_rows, green_first))
      BAND_RED:   return RGB_RED;
      BAND_GREEN: return RGB_GREEN;
      default:    return RGB_WHITE;
    endcase
  endfunction

endpackage

// File: rtl/vga_pixel_gen_if.sv
// Framebuffer read port: registered address/enable out, 1-bit data back one
// cycle later from a synchronous RAM. MSB of the address selects the bank.
interface vga_pixel_gen_if
  import vga_pixel_gen_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [ADDR_W:0] fb_addr;
  logic            fb_rd;
  logic            fb_data;

  // Pixel generator side.
  modport master (output fb_addr, output fb_rd, input fb_data);
  // RAM side.
  modport slave  (input fb_addr, input fb_rd, output fb_data);
endinterface

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register used to keep syncs/qualifiers aligned with the
// pixel pipeline. Reset value is a parameter so idle-high syncs come out high.
module vga_sync_delay #(
  parameter int               DEPTH     = 3,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  // Shift din through DEPTH stages; every stage is reset so no stale sync
  // survives a mid-line reset.
  // NOTE: non-blocking assignments make every stage sample the pre-edge value
  // of its neighbour; blocking ones would collapse the chain into one stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= RESET_VAL;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vga_pixel_gen.sv
// VGA pixel generator: maps active-area coordinates onto a scaled 1-bpp
// double-buffered playfield, applies the red/white/green band overlay and
// delivers RGB with syncs delayed to match (3 clk end to end).
module vga_pixel_gen
  import vga_pixel_gen_pkg::*;
#(
  parameter int FB_W        = DEF_FB_W,
  parameter int FB_H        = DEF_FB_H,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int ORIGIN_X    = DEF_ORIGIN_X,
  parameter int ORIGIN_Y    = DEF_ORIGIN_Y,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int RED_ROWS    = DEF_RED_ROWS,
  parameter int GREEN_ROWS  = DEF_GREEN_ROWS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   de_in,
  input  logic                   frame_in,
  input  coord_t                 ux,
  input  coord_t                 uy,
  input  logic                   swap_req,
  output logic                   swap_ack,
  vga_pixel_gen_if.master        fb,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de_out,
  output rgb_t                   rgb
);

  localparam coord_t X_LO        = COORD_W'(ORIGIN_X);
  localparam coord_t X_HI        = COORD_W'(ORIGIN_X + (FB_W << SCALE_SHIFT));
  localparam coord_t Y_LO        = COORD_W'(ORIGIN_Y);
  localparam coord_t Y_HI        = COORD_W'(ORIGIN_Y + (FB_H << SCALE_SHIFT));
  localparam coord_t RED_LIMIT   = COORD_W'(RED_ROWS);
  localparam coord_t GREEN_FIRST = COORD_W'(FB_H - GREEN_ROWS);

  // A bank must hold the whole playfield.
  if (FB_W * FB_H > (1 << ADDR_W)) begin : g_fb_too_big
    $error("vga_pixel_gen: FB_W*FB_H exceeds 2**ADDR_W");
  end

  logic              bank;
  logic              in_field;
  coord_t            fx;
  coord_t            fy;
  logic [ADDR_W-1:0] addr_lin;

  logic              s1_field;
  coord_t            s1_fy;
  logic              s2_field;
  coord_t            s2_fy;

  // S1 combinational: playfield hit test and linear framebuffer address.
  // The subtractions are only consumed when the range test passes.
  // NOTE: every output gets a default at the top so no path leaves a latch.
  always_comb begin
    in_field = 1'b0;
    fx       = '0;
    fy       = '0;
    addr_lin = '0;
    in_field = de_in && (ux >= X_LO) && (ux < X_HI) && (uy >= Y_LO) && (uy < Y_HI);
    fx       = (ux - X_LO) >> SCALE_SHIFT;
    fy       = (uy - Y_LO) >> SCALE_SHIFT;
    addr_lin = ADDR_W'(fy) * ADDR_W'(FB_W) + ADDR_W'(fx);
  end

  // Frame-aligned bank swap; ack pulses for the single cycle after the swap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank     <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= frame_in & swap_req;
      if (frame_in && swap_req) bank <= ~bank;
    end
  end

  // S1 register: issue the RAM read; the address holds outside the playfield
  // so the RAM bus does not toggle during borders and blanking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb.fb_rd   <= 1'b0;
      fb.fb_addr <= '0;
      s1_field   <= 1'b0;
      s1_fy      <= '0;
    end else begin
      fb.fb_rd <= in_field;
      s1_field <= in_field;
      s1_fy    <= fy;
      if (in_field) fb.fb_addr <= {bank, addr_lin};
    end
  end

  // S2 register: carry the hit flag and row alongside the RAM access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_field <= 1'b0;
      s2_fy    <= '0;
    end else begin
      s2_field <= s1_field;
      s2_fy    <= s1_fy;
    end
  end

  // S3 register: colour from RAM data and band; in_field already implies de.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rgb <= RGB_BLACK;
    else      rgb <= pixel_colour(s2_field & fb.fb_data, s2_fy, RED_LIMIT, GREEN_FIRST);
  end

  logic [1:0] sync_q;

  vga_sync_delay #(
    .DEPTH     (3),
    .WIDTH     (2),
    .RESET_VAL (2'b11)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({hsync_in, vsync_in}),
    .dout (sync_q)
  );

  assign hsync = sync_q[1];
  assign vsync = sync_q[0];

  vga_sync_delay #(
    .DEPTH     (3),
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_de_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (de_in),
    .dout (de_out)
  );

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Directed bench for vga_pixel_gen: reset, latency, address mapping, colour
// bands and bank swapping against hand-computed values.
module tb_vga_pixel_gen;
  import vga_pixel_gen_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   hsync_in, vsync_in, de_in, frame_in, swap_req;
  coord_t ux, uy;
  logic   swap_ack, hsync, vsync, de_out;
  rgb_t   rgb;
  logic   ram_fill;

  int checks = 0;
  int errors = 0;

  vga_pixel_gen_if #(.ADDR_W(16)) fb_bus ();

  vga_pixel_gen dut (
    .clk      (clk),
    .rst      (rst),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .de_in    (de_in),
    .frame_in (frame_in),
    .ux       (ux),
    .uy       (uy),
    .swap_req (swap_req),
    .swap_ack (swap_ack),
    .fb       (fb_bus.master),
    .hsync    (hsync),
    .vsync    (vsync),
    .de_out   (de_out),
    .rgb      (rgb)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model: every location reads as ram_fill, 1 cycle latency.
  initial fb_bus.fb_data = 1'b0;
  always @(posedge clk) if (fb_bus.fb_rd) fb_bus.fb_data <= ram_fill;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One pixel through the pipe: address after 1 clk, colour after 3 clk.
  task automatic probe(input coord_t x, input coord_t y, input logic exp_rd,
                       input logic [16:0] exp_addr, input rgb_t exp_rgb);
    ux = x; uy = y; de_in = 1'b1;
    tick();
    check($sformatf("fb_rd(%0d,%0d)", x, y), 32'(fb_bus.fb_rd), 32'(exp_rd));
    check($sformatf("fb_addr(%0d,%0d)", x, y), 32'(fb_bus.fb_addr), 32'(exp_addr));
    de_in = 1'b0;
    tick();
    tick();
    check($sformatf("rgb(%0d,%0d)", x, y), 32'(rgb), 32'(exp_rgb));
  endtask

  int first_h, cnt_h, first_de, cnt_de, cnt_rgb;

  initial begin
    // Reset held mid-line with active video on the inputs.
    rst = 1'b0; ram_fill = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b1; de_in = 1'b1; frame_in = 1'b0; swap_req = 1'b0;
    ux = 11'd100; uy = 11'd10;
    tick(); tick();
    check("rst_hsync",    32'(hsync),          32'd1);
    check("rst_vsync",    32'(vsync),          32'd1);
    check("rst_de_out",   32'(de_out),         32'd0);
    check("rst_rgb",      32'(rgb),            32'h000);
    check("rst_fb_rd",    32'(fb_bus.fb_rd),   32'd0);
    check("rst_fb_addr",  32'(fb_bus.fb_addr), 32'd0);
    check("rst_swap_ack", 32'(swap_ack),       32'd0);

    // Release: (100,10) -> fx=2 fy=5 -> addr 1122, red band, de after 3 clk.
    rst = 1'b1; hsync_in = 1'b1;
    tick();
    check("post_rst_fb_rd",   32'(fb_bus.fb_rd),   32'd1);
    check("post_rst_fb_addr", 32'(fb_bus.fb_addr), 32'd1122);
    de_in = 1'b0;
    tick();
    check("post_rst_de_c2",   32'(de_out), 32'd0);
    tick();
    check("post_rst_de_c3",   32'(de_out), 32'd1);
    check("post_rst_rgb_c3",  32'(rgb),    32'hF00);
    tick();
    check("post_rst_de_c4",   32'(de_out), 32'd0);
    check("post_rst_rgb_c4",  32'(rgb),    32'h000);

    // 96-cycle hsync and de pulses outside the playfield.
    ux = 11'd0; uy = 11'd600;
    hsync_in = 1'b0; de_in = 1'b1;
    first_h = -1; cnt_h = 0; first_de = -1; cnt_de = 0; cnt_rgb = 0;
    for (int i = 1; i <= 110; i++) begin
      tick();
      if (i == 96) begin
        hsync_in = 1'b1;
        de_in    = 1'b0;
      end
      if (!hsync) begin
        cnt_h++;
        if (first_h < 0) first_h = i;
      end
      if (de_out) begin
        cnt_de++;
        if (first_de < 0) first_de = i;
      end
      if (rgb != 12'h000) cnt_rgb++;
    end
    check("hsync_first", 32'(first_h),  32'd3);
    check("hsync_len",   32'(cnt_h),    32'd96);
    check("de_first",    32'(first_de), 32'd3);
    check("de_len",      32'(cnt_de),   32'd96);
    check("border_rgb",  32'(cnt_rgb),  32'd0);

    // Address mapping, boundaries and colour bands (bank 0, RAM all ones).
    probe(11'd96,  11'd0,   1'b1, 17'd0,     12'hF00);
    probe(11'd97,  11'd0,   1'b1, 17'd0,     12'hF00);
    probe(11'd98,  11'd0,   1'b1, 17'd1,     12'hF00);
    probe(11'd543, 11'd479, 1'b1, 17'd53759, 12'h0F0);
    probe(11'd95,  11'd0,   1'b0, 17'd53759, 12'h000);
    probe(11'd544, 11'd0,   1'b0, 17'd53759, 12'h000);
    probe(11'd96,  11'd62,  1'b1, 17'd6944,  12'hF00);
    probe(11'd96,  11'd64,  1'b1, 17'd7168,  12'hFFF);
    probe(11'd96,  11'd366, 1'b1, 17'd40992, 12'hFFF);
    probe(11'd96,  11'd368, 1'b1, 17'd41216, 12'h0F0);
    probe(11'd96,  11'd480, 1'b0, 17'd41216, 12'h000);
    ram_fill = 1'b0;
    probe(11'd200, 11'd200, 1'b1, 17'd22452, 12'h000);
    ram_fill = 1'b1;

    // Request raised early, then taken at the frame pulse.
    swap_req = 1'b1;
    tick();
    check("ack_no_frame", 32'(swap_ack), 32'd0);
    frame_in = 1'b1;
    tick();
    check("ack_pulse", 32'(swap_ack), 32'd1);
    frame_in = 1'b0; swap_req = 1'b0;
    tick();
    check("ack_one_cycle", 32'(swap_ack), 32'd0);
    probe(11'd96, 11'd0, 1'b1, 17'h10000, 12'hF00);

    // Frame with no request: bank stays 1, no ack.
    frame_in = 1'b1;
    tick();
    check("ack_no_req", 32'(swap_ack), 32'd0);
    frame_in = 1'b0;
    tick();
    probe(11'd98, 11'd0, 1'b1, 17'h10001, 12'hF00);

    // Request rising on the frame cycle itself: bank back to 0.
    frame_in = 1'b1; swap_req = 1'b1;
    tick();
    check("ack_same_cycle", 32'(swap_ack), 32'd1);
    frame_in = 1'b0; swap_req = 1'b0;
    tick();
    probe(11'd96, 11'd0, 1'b1, 17'd0, 12'hF00);

    // Reset the cycle after a swap is taken: bank and ack cleared.
    frame_in = 1'b1; swap_req = 1'b1;
    tick();
    frame_in = 1'b0; rst = 1'b0;
    #1;
    check("rst_mid_swap_ack",  32'(swap_ack),       32'd0);
    check("rst_mid_swap_addr", 32'(fb_bus.fb_addr), 32'd0);
    tick();
    swap_req = 1'b0; rst = 1'b1;
    tick();
    probe(11'd98, 11'd0, 1'b1, 17'd1, 12'hF00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_gen.md
Name: vga_pixel_gen

Overview:
- Downstream stage of the VGA timing generator. Consumes hsync/vsync/data_enable/frame and active-area pixel coordinates; produces 12-bit RGB and latency-matched syncs for the DAC/connector.
- Maps screen coordinates onto a scaled 1-bpp playfield framebuffer held in an external synchronous RAM, then applies the arcade colour-band overlay.
- Owns double-buffer bank selection through a frame-aligned swap handshake with the game logic.

Parameters:
- FB_W, 224, playfield width in framebuffer pixels
- FB_H, 240, playfield height in framebuffer pixels
- SCALE_SHIFT, 1, log2 of the screen-pixels-per-framebuffer-pixel scale in both axes
- ORIGIN_X, 96, screen x of the playfield's left edge
- ORIGIN_Y, 0, screen y of the playfield's top edge
- ADDR_W, 16, framebuffer address width per bank
- RED_ROWS, 32, top framebuffer rows drawn red
- GREEN_ROWS, 56, bottom framebuffer rows drawn green

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- hsync_in  in  1  from timing generator, active low
- vsync_in  in  1  from timing generator, active low
- de_in  in  1  active-video qualifier
- frame_in  in  1  one-cycle start-of-frame pulse
- ux  in  11  active-area x, 0-based, valid when de_in=1
- uy  in  11  active-area y, 0-based, valid when de_in=1
- swap_req  in  1  game logic requests a bank swap
- swap_ack  out  1  one-cycle pulse: swap taken at this frame
- fb_addr  out  ADDR_W+1  RAM read address; MSB is the bank
- fb_rd  out  1  RAM read enable
- fb_data  in  1  RAM read data, valid 1 cycle after fb_rd
- hsync  out  1  delayed hsync_in
- vsync  out  1  delayed vsync_in
- de_out  out  1  delayed de_in
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}

Behaviour:
- Reset (rst=0, asynchronous): hsync=1, vsync=1, de_out=0, rgb=0, fb_rd=0, fb_addr=0, swap_ack=0, bank=0, all pipeline valid/in-field bits cleared. Reset mid-line is legal; outputs are clean from the first post-reset cycle.
- Fixed latency of 3 clk from inputs to hsync/vsync/de_out/rgb. Syncs and de travel through a 3-deep shift register.
- S1 (cycle 1):
  - in_field = de_in & ux in [ORIGIN_X, ORIGIN_X+(FB_W<<SCALE_SHIFT)) & uy in [ORIGIN_Y, ORIGIN_Y+(FB_H<<SCALE_SHIFT)).
  - fx = (ux-ORIGIN_X)>>SCALE_SHIFT; fy = (uy-ORIGIN_Y)>>SCALE_SHIFT.
  - fb_addr = {bank, fy*FB_W+fx} is registered. fb_rd = in_field.
  - fy is carried forward.
  - When in_field=0, fb_addr holds its previous value (no toggling).
- S2 (cycle 2): RAM returns fb_data. The in_field flag and fy advance one stage.
- S3 (cycle 3): rgb is registered.
  - If !de: 12'h000.
  - If !in_field or fb_data=0: 12'h000.
  - If fy<RED_ROWS: 12'hF00.
  - If fy>=FB_H-GREEN_ROWS: 12'h0F0.
  - Otherwise: 12'hFFF.
- Arithmetic:
  - Subtractions use unsigned 11-bit values, guarded by the range compare, so there is no underflow use.
  - The fy*FB_W product is ADDR_W bits wide. FB_W*FB_H must be ≤ 2^ADDR_W; this is checked by an elaboration-time assertion.
- Bank swap:
  - On a cycle with frame_in=1 and swap_req=1: bank toggles (registered) and swap_ack=1 for exactly that next cycle.
  - With frame_in=1 and swap_req=0: no change.
  - The new bank applies to every fb_addr issued after that edge.
  - swap_req rising in the same cycle as frame_in counts.
  - The requester holds swap_req until it sees swap_ack, then deasserts it. A request held through two frames swaps twice; this is by design.
- Boundaries:
  - First/last playfield column and row are included.
  - ux=ORIGIN_X-1 and ux=ORIGIN_X+448 are outside the playfield (black).
  - Band edges: fy=RED_ROWS-1 is red, fy=RED_ROWS is white.
  - de_in falling mid-pipeline blanks exactly 3 cycles later.

Decomposition:
- Shared constants go in util/constants.v alongside the timing constants:
  - RGB colour constants: black, white, red, green.
  - Playfield geometry defaults.
- One sub-module: vga_sync_delay.
  - Parameterised depth and width; asynchronous active-low reset.
  - Reset value given by a parameter (1 for syncs, 0 for de).
  - Reusable by later overlay stages.

Test Plan:
- Reset: hold rst=0 mid-line with de_in=1 → hsync=vsync=1, de_out=0, rgb=0, fb_rd=0. Release → first output valid 3 cycles after the first input.
- Latency/alignment: pulse hsync_in low for 96 cycles → hsync low for exactly 96 cycles, starting 3 cycles later. de_out tracks de_in identically.
- Address mapping:
  - ux=96, uy=0 → fb_addr=0, fb_rd=1.
  - ux=97 → 0 (same pixel).
  - ux=98 → 1.
  - ux=543, uy=479 → 53759.
  - ux=95 or 544 → fb_rd=0, rgb=0.
- Colour bands (RAM model returns 1 everywhere):
  - uy=62 (fy=31) → rgb=F00.
  - uy=64 (fy=32) → FFF.
  - uy=368 (fy=184) → 0F0.
  - With fb_data=0 → 000.
- Bank swap:
  - swap_req=1, then frame_in pulse → swap_ack high for 1 cycle; the next fb_addr MSB=1.
  - No request over a frame → MSB unchanged, no ack.
  - Request asserted on the same cycle as frame_in → accepted.
- Reset mid-swap: assert rst the cycle after frame_in with swap_req=1 → bank=0, swap_ack=0.
